sobel_line_feeder: RTL and testbench

Write-side controller for the Sobel line-buffer chain. It accepts a raster pixel stream over a valid/ready handshake and drives the shift enable and shift data into the cascaded shift-register line buffers. It tracks column and row position, and flags the shifts after which a full 3x3 neighbourhood is present, so the window/gradient stage can sample it. It sits between the pixel source and the line-buffer chain, as the producer for those buffers.

---
 rtl/sobel_line_feeder.sv | 110 +++++++++++
 tb/tb_sobel_line_feeder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_line_feeder.sv
// rtl/sobel_line_feeder.sv - write-side controller feeding the Sobel line-buffer chain
// Turns an accepted raster pixel stream into line-buffer shifts tagged with position and window flags.
module sobel_line_feeder #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int DW    = 8,
  localparam int CW   = $clog2(IMG_W),
  localparam int RW   = $clog2(IMG_H)
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic          In_Valid,
  input  logic          In_SOF,
  input  logic [DW-1:0] In_Data,
  output logic          In_Ready,
  input  logic          Stall,
  output logic          Shift_En,
  output logic [DW-1:0] Shift_Data,
  output logic          Win_Valid,
  output logic [CW-1:0] Col,
  output logic [RW-1:0] Row,
  output logic          Frame_Done,
  output logic          Err
);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  state_t        state;
  logic [CW-1:0] col_nxt;
  logic [RW-1:0] row_nxt;
  logic          xfer;

  assign In_Ready = !Stall && (state != DONE);
  assign xfer     = In_Valid && In_Ready;

  // col_nxt/row_nxt hold the position the next accepted pixel will take
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state      <= IDLE;
      col_nxt    <= '0;
      row_nxt    <= '0;
      Shift_En   <= 1'b0;
      Shift_Data <= '0;
      Win_Valid  <= 1'b0;
      Col        <= '0;
      Row        <= '0;
      Frame_Done <= 1'b0;
      Err        <= 1'b0;
    end else begin
      Shift_En   <= 1'b0;
      Win_Valid  <= 1'b0;
      Frame_Done <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            if (In_SOF) begin
              Shift_En   <= 1'b1;
              Shift_Data <= In_Data;
              Col        <= '0;
              Row        <= '0;
              col_nxt    <= CW'(1);
              row_nxt    <= '0;
              state      <= STREAM;
            end else begin
              Err <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (xfer) begin
            Shift_En   <= 1'b1;
            Shift_Data <= In_Data;
            if (In_SOF) begin
              // early restart: abandon the current frame and begin anew at the origin
              Err     <= 1'b1;
              Col     <= '0;
              Row     <= '0;
              col_nxt <= CW'(1);
              row_nxt <= '0;
            end else begin
              Col       <= col_nxt;
              Row       <= row_nxt;
              Win_Valid <= (row_nxt >= ROW_TWO) && (col_nxt >= COL_TWO);
              if (col_nxt == COL_LAST) begin
                col_nxt <= '0;
                if (row_nxt == ROW_LAST) begin
                  Frame_Done <= 1'b1;
                  row_nxt    <= '0;
                  state      <= DONE;
                end else begin
                  row_nxt <= row_nxt + RW'(1);
                end
              end else begin
                col_nxt <= col_nxt + CW'(1);
              end
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_line_feeder.sv
// tb/tb_sobel_line_feeder.sv - scoreboard bench for sobel_line_feeder
module tb_sobel_line_feeder;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int BW = 64;
  localparam int BH = 64;

  typedef struct {
    logic [7:0] d;
    int         c;
    int         r;
    bit         w;
    bit         f;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 0, in_sof = 0, stall = 0;
  logic [7:0] in_data = '0;
  logic       in_ready, shift_en, win_valid, frame_done, err;
  logic [7:0] shift_data;
  logic [1:0] col, row;

  logic       b_valid = 0, b_sof = 0, b_stall = 0;
  logic [7:0] b_din = '0;
  logic       b_ready, b_shift, b_win, b_fd, b_err;
  logic [7:0] b_data;
  logic [5:0] b_col, b_row;

  sobel_line_feeder #(.IMG_W(W), .IMG_H(H), .DW(8)) u_dut (
    .CLK(clk), .RST_n(rst_n), .In_Valid(in_valid), .In_SOF(in_sof), .In_Data(in_data),
    .In_Ready(in_ready), .Stall(stall), .Shift_En(shift_en), .Shift_Data(shift_data),
    .Win_Valid(win_valid), .Col(col), .Row(row), .Frame_Done(frame_done), .Err(err)
  );

  sobel_line_feeder #(.IMG_W(BW), .IMG_H(BH), .DW(8)) u_big (
    .CLK(clk), .RST_n(rst_n), .In_Valid(b_valid), .In_SOF(b_sof), .In_Data(b_din),
    .In_Ready(b_ready), .Stall(b_stall), .Shift_En(b_shift), .Shift_Data(b_data),
    .Win_Valid(b_win), .Col(b_col), .Row(b_row), .Frame_Done(b_fd), .Err(b_err)
  );

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  exp_t mon_e;
  exp_t last_sh = '{d: 8'h00, c: 0, r: 0, w: 1'b0, f: 1'b0};

  // frame-level reference: position is just the pixel index within the frame
  bit m_in_frame = 0;
  bit m_done = 0;
  bit m_err = 0;
  int m_idx = 0;

  int b_shifts = 0, b_wins = 0, b_fds = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] d, input int c, input int r);
    exp_t e;
    e.d = d;
    e.c = c;
    e.r = r;
    e.w = (r >= 2) && (c >= 2);
    e.f = (c == W - 1) && (r == H - 1);
    q.push_back(e);
  endtask

  task automatic model_accept(input bit sof, input logic [7:0] d);
    if (sof) begin
      if (m_in_frame) m_err = 1;
      push(d, 0, 0);
      m_in_frame = 1;
      m_idx = 1;
    end else if (!m_in_frame) begin
      m_err = 1;
    end else begin
      push(d, m_idx % W, m_idx / W);
      if (m_idx == W * H - 1) begin
        m_in_frame = 0;
        m_done = 1;
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic drive(input bit v, input bit sof, input logic [7:0] d, input bit st, output bit acc);
    bit exp_rdy;
    @(negedge clk);
    chk(err === m_err, "err_flag", err, m_err);
    in_valid = v;
    in_sof   = sof;
    in_data  = d;
    stall    = st;
    #1;
    exp_rdy = !st && !m_done;
    chk(in_ready === exp_rdy, "in_ready", in_ready, exp_rdy);
    m_done = 0;
    acc = v && exp_rdy;
    if (acc) model_accept(sof, d);
  endtask

  task automatic send_pixel(input bit sof, input logic [7:0] d);
    bit acc;
    acc = 0;
    for (int i = 0; i < 8 && !acc; i++) drive(1, sof, d, 0, acc);
    if (!acc) chk(0, "accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive(0, 0, 8'h00, 0, acc);
  endtask

  task automatic check_reset_vals();
    chk(shift_en === 1'b0, "rst_shift_en", shift_en, 0);
    chk(win_valid === 1'b0, "rst_win_valid", win_valid, 0);
    chk(frame_done === 1'b0, "rst_frame_done", frame_done, 0);
    chk(err === 1'b0, "rst_err", err, 0);
    chk(shift_data === 8'h00, "rst_shift_data", shift_data, 0);
    chk(col === 2'd0, "rst_col", col, 0);
    chk(row === 2'd0, "rst_row", row, 0);
    chk(in_ready === !stall, "rst_in_ready", in_ready, !stall);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (shift_en) begin
        if (q.size() == 0) begin
          chk(0, "unexpected_shift", shift_data, 0);
        end else begin
          mon_e = q.pop_front();
          chk({shift_data, col, row, win_valid, frame_done} ===
              {mon_e.d, 2'(mon_e.c), 2'(mon_e.r), mon_e.w, mon_e.f},
              "shift", {shift_data, col, row, win_valid, frame_done},
              {mon_e.d, 2'(mon_e.c), 2'(mon_e.r), mon_e.w, mon_e.f});
          last_sh = mon_e;
        end
      end else begin
        chk({win_valid, frame_done, shift_data, col, row} ===
            {2'b00, last_sh.d, 2'(last_sh.c), 2'(last_sh.r)},
            "hold", {win_valid, frame_done, shift_data, col, row},
            {2'b00, last_sh.d, 2'(last_sh.c), 2'(last_sh.r)});
      end
    end
    if (b_shift) b_shifts++;
    if (b_win) b_wins++;
    if (b_fd) b_fds++;
  end

  initial begin
    bit acc;
    #12;
    check_reset_vals();
    @(negedge clk);
    rst_n = 1;

    // clean frame 1..12
    for (int p = 1; p <= 12; p++) send_pixel(p == 1, 8'(p));
    idle(3);

    // same frame with a 3-cycle stall after pixel 5
    for (int p = 1; p <= 5; p++) send_pixel(p == 1, 8'(p));
    for (int i = 0; i < 3; i++) drive(1, 0, 8'd6, 1, acc);
    for (int p = 6; p <= 12; p++) send_pixel(0, 8'(p));
    idle(2);

    // stray pixel in IDLE, then a correct frame
    drive(1, 0, 8'h55, 0, acc);
    idle(1);
    for (int p = 1; p <= 12; p++) send_pixel(p == 1, 8'(p));
    idle(2);

    // early restart at pixel 7
    for (int p = 1; p <= 6; p++) send_pixel(p == 1, 8'(p));
    send_pixel(1, 8'd7);
    for (int p = 8; p <= 18; p++) send_pixel(0, 8'(p));
    idle(2);

    // asynchronous reset mid-row at Col=2
    send_pixel(1, 8'h21);
    send_pixel(0, 8'h22);
    send_pixel(0, 8'h23);
    @(negedge clk);
    in_valid = 0;
    in_sof = 0;
    stall = 0;
    #2 rst_n = 0;
    #1 check_reset_vals();
    q.delete();
    last_sh = '{d: 8'h00, c: 0, r: 0, w: 1'b0, f: 1'b0};
    m_in_frame = 0;
    m_done = 0;
    m_err = 0;
    m_idx = 0;
    @(negedge clk);
    #2 rst_n = 1;
    drive(1, 0, 8'h30, 0, acc);
    for (int p = 1; p <= 12; p++) send_pixel(p == 1, 8'(p + 64));
    idle(2);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      bit v, s, st;
      v  = $urandom_range(0, 3) != 0;
      st = $urandom_range(0, 9) == 0;
      s  = m_in_frame ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 4) != 0);
      drive(v, s, 8'($urandom), st, acc);
    end
    idle(3);
    chk(q.size() == 0, "queue_drained", q.size(), 0);

    // full 64x64 frame on the large instance
    b_shifts = 0;
    b_wins = 0;
    b_fds = 0;
    for (int i = 0; i < BW * BH; i++) begin
      @(negedge clk);
      b_valid = 1;
      b_sof   = (i == 0);
      b_din   = 8'(i);
    end
    @(negedge clk);
    b_valid = 0;
    b_sof = 0;
    repeat (4) @(negedge clk);
    chk(b_shifts == BW * BH, "big_shifts", b_shifts, BW * BH);
    chk(b_wins == (BW - 2) * (BH - 2), "big_windows", b_wins, (BW - 2) * (BH - 2));
    chk(b_fds == 1, "big_frame_done", b_fds, 1);
    chk(b_err === 1'b0, "big_err", b_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
